// File: rtl/pixel_compositor.sv
// pixel_compositor
//   Per-pixel colour compositor for the raycaster display. Draws the minimap
//   overlay (ray dots, player disc, walls) or the first-person wall column and
//   registers the result as RGB444. Player state is latched on frame_start so
//   a frame is drawn from one consistent snapshot. Ray-dot positions are
//   computed once per frame by a small FSM into a shadow set. The shadow set
//   is committed to the active set only when it is complete.
//
// Ports
//   Clk              pixel clock
//   Reset            synchronous, active-high
//   frame_start      one-cycle pulse at vblank start
//   de               display enable for the current pixel
//   DrawX, DrawY     current pixel (screen coordinates)
//   X, Y, size       player position and disc radius (map units)
//   x_vec, y_vec     signed view vector
//   map_en           1 = draw the minimap overlay
//   wall_on          minimap wall present at this pixel
//   wall_color       minimap wall colour, RGB444
//   memdata          column data: [11:8] shade, [7:0] half-height/2
//   Red/Green/Blue   registered pixel colour (2-cycle latency)
//   out_valid        de delayed by 2 cycles
//   dots_ready       committed dot set is valid for the current frame
module pixel_compositor #(
    parameter int MAP_W     = 160,
    parameter int MAP_H     = 120,
    parameter int MAP_SHIFT = 2,
    parameter int N_DOTS    = 9,
    parameter int RAY_HALF  = 1,
    parameter int Y_CENTER  = 240
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic        de,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  X,
    input  logic [9:0]  Y,
    input  logic [9:0]  size,
    input  logic [7:0]  x_vec,
    input  logic [7:0]  y_vec,
    input  logic        map_en,
    input  logic        wall_on,
    input  logic [11:0] wall_color,
    input  logic [11:0] memdata,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic        out_valid,
    output logic        dots_ready
);

    localparam int KW        = $clog2(N_DOTS);
    localparam int ACC_W     = 8 + KW;
    localparam int DOT_SHIFT = $clog2(N_DOTS - 1);
    localparam int MW        = 8 + MAP_SHIFT;
    localparam logic [KW-1:0]    K_LAST = KW'(N_DOTS - 1);
    localparam logic signed [15:0] RH   = 16'(RAY_HALF);
    localparam logic signed [11:0] YC   = 12'(Y_CENTER);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    state_t state_reg, state_next;
    logic   calc_en, commit_en;

    logic [9:0]  x_lat_reg, y_lat_reg, size_lat_reg;
    logic [7:0]  xv_lat_reg, yv_lat_reg;
    logic [KW-1:0] k_reg;
    logic signed [ACC_W-1:0] acc_x_reg, acc_y_reg;
    logic        dots_ready_reg;

    // ---------------- dot FSM ----------------
    // frame_start wins in every state: it re-latches and restarts at k=0,
    // so a pending shadow set is never committed.
    always_comb begin
        state_next = state_reg;
        calc_en    = 1'b0;
        commit_en  = 1'b0;
        if (frame_start) begin
            state_next = CALC;
        end else begin
            case (state_reg)
                CALC: begin
                    calc_en = 1'b1;
                    if (k_reg == K_LAST) state_next = COMMIT;
                end
                COMMIT: begin
                    commit_en  = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= IDLE;
            x_lat_reg      <= '0;
            y_lat_reg      <= '0;
            size_lat_reg   <= '0;
            xv_lat_reg     <= '0;
            yv_lat_reg     <= '0;
            k_reg          <= '0;
            acc_x_reg      <= '0;
            acc_y_reg      <= '0;
            dots_ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (frame_start) begin
                x_lat_reg      <= X;
                y_lat_reg      <= Y;
                size_lat_reg   <= size;
                xv_lat_reg     <= x_vec;
                yv_lat_reg     <= y_vec;
                k_reg          <= '0;
                acc_x_reg      <= '0;
                acc_y_reg      <= '0;
                dots_ready_reg <= 1'b0;
            end else if (calc_en) begin
                k_reg     <= k_reg + KW'(1);
                acc_x_reg <= acc_x_reg + $signed({{(ACC_W-8){xv_lat_reg[7]}}, xv_lat_reg});
                acc_y_reg <= acc_y_reg + $signed({{(ACC_W-8){yv_lat_reg[7]}}, yv_lat_reg});
            end else if (commit_en) begin
                dots_ready_reg <= 1'b1;
            end
        end
    end

    // acc holds k*vec; the arithmetic shift scales it so dot N_DOTS-1 lands
    // one full view vector away from the player.
    logic signed [ACC_W-1:0] acc_x_shr, acc_y_shr;
    logic signed [10:0]      dot_x_new, dot_y_new;
    assign acc_x_shr = acc_x_reg >>> DOT_SHIFT;
    assign acc_y_shr = acc_y_reg >>> DOT_SHIFT;
    assign dot_x_new = $signed({1'b0, x_lat_reg}) + 11'(acc_x_shr);
    assign dot_y_new = $signed({1'b0, y_lat_reg}) + 11'(acc_y_shr);

    // ---------------- S1: hit terms ----------------
    logic [MW-1:0]      map_x, map_y;
    logic signed [15:0] map_x_s, map_y_s;
    logic [N_DOTS-1:0]  dot_hit_vec;

    assign map_x   = {DrawX[7:0], {MAP_SHIFT{1'b0}}};
    assign map_y   = {DrawY[7:0], {MAP_SHIFT{1'b0}}};
    assign map_x_s = $signed({{(16-MW){1'b0}}, map_x});
    assign map_y_s = $signed({{(16-MW){1'b0}}, map_y});

    generate
        for (genvar gi = 0; gi < N_DOTS; gi++) begin : g_dot
            logic signed [10:0] shadow_x_reg, shadow_y_reg;
            logic signed [10:0] active_x_reg, active_y_reg;
            logic signed [15:0] diff_x, diff_y;

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    shadow_x_reg <= '0;
                    shadow_y_reg <= '0;
                    active_x_reg <= '0;
                    active_y_reg <= '0;
                end else begin
                    if (calc_en && (k_reg == KW'(gi))) begin
                        shadow_x_reg <= dot_x_new;
                        shadow_y_reg <= dot_y_new;
                    end
                    if (commit_en) begin
                        active_x_reg <= shadow_x_reg;
                        active_y_reg <= shadow_y_reg;
                    end
                end
            end

            // Differences are wide enough that negative dot coordinates
            // never wrap into a false hit.
            assign diff_x = map_x_s - 16'(active_x_reg);
            assign diff_y = map_y_s - 16'(active_y_reg);
            assign dot_hit_vec[gi] = (diff_x >= -RH) && (diff_x <= RH) &&
                                     (diff_y >= -RH) && (diff_y <= RH);
        end
    endgenerate

    logic               in_map, player_hit, above, below;
    logic signed [31:0] dx32, dy32, dist32, rad32;
    logic [8:0]         h9;
    logic signed [11:0] y_s, h_s;

    assign in_map = map_en && (DrawX <= 10'(MAP_W)) && (DrawY <= 10'(MAP_H));
    assign dx32   = $signed({{(32-MW){1'b0}}, map_x}) - $signed({22'b0, x_lat_reg});
    assign dy32   = $signed({{(32-MW){1'b0}}, map_y}) - $signed({22'b0, y_lat_reg});
    assign dist32 = dx32 * dx32 + dy32 * dy32;
    assign rad32  = $signed({22'b0, size_lat_reg}) * $signed({22'b0, size_lat_reg});
    assign player_hit = (dist32 <= rad32);

    // Column bounds are compared signed so a tall column (h > Y_CENTER)
    // gives a negative top instead of wrapping.
    assign h9    = {memdata[7:0], 1'b0};
    assign y_s   = $signed({2'b00, DrawY});
    assign h_s   = $signed({3'b000, h9});
    assign above = (y_s < (YC - h_s));
    assign below = (y_s > (YC + h_s));

    logic        s1_de_reg, s1_in_map_reg, s1_dot_reg, s1_player_reg;
    logic        s1_wall_reg, s1_above_reg, s1_below_reg;
    logic [11:0] s1_wall_color_reg;
    logic [3:0]  s1_shade_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_de_reg         <= 1'b0;
            s1_in_map_reg     <= 1'b0;
            s1_dot_reg        <= 1'b0;
            s1_player_reg     <= 1'b0;
            s1_wall_reg       <= 1'b0;
            s1_above_reg      <= 1'b0;
            s1_below_reg      <= 1'b0;
            s1_wall_color_reg <= '0;
            s1_shade_reg      <= '0;
        end else begin
            s1_de_reg         <= de;
            s1_in_map_reg     <= in_map;
            s1_dot_reg        <= |dot_hit_vec;
            s1_player_reg     <= player_hit;
            s1_wall_reg       <= wall_on;
            s1_above_reg      <= above;
            s1_below_reg      <= below;
            s1_wall_color_reg <= wall_color;
            s1_shade_reg      <= memdata[11:8];
        end
    end

    // ---------------- S2: colour select ----------------
    logic [11:0] rgb_next, rgb_reg;
    logic        out_valid_reg;

    always_comb begin
        rgb_next = 12'h000;
        if (s1_de_reg) begin
            if (s1_in_map_reg) begin
                if (s1_dot_reg)         rgb_next = 12'hFFF;
                else if (s1_player_reg) rgb_next = 12'hF70;
                else if (s1_wall_reg)   rgb_next = s1_wall_color_reg;
                else                    rgb_next = 12'h004;
            end else begin
                if (s1_above_reg)       rgb_next = 12'h337;
                else if (s1_below_reg)  rgb_next = 12'h733;
                else                    rgb_next = {s1_shade_reg, s1_shade_reg, s1_shade_reg};
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rgb_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            rgb_reg       <= rgb_next;
            out_valid_reg <= s1_de_reg;
        end
    end

    assign Red        = rgb_reg[11:8];
    assign Green      = rgb_reg[7:4];
    assign Blue       = rgb_reg[3:0];
    assign out_valid  = out_valid_reg;
    assign dots_ready = dots_ready_reg;

endmodule

// File: tb/tb_pixel_compositor.sv
// Testbench for pixel_compositor. Stimulus pushes the expected output of each
// pixel into a queue tagged with the cycle it should appear on. An
// independent monitor pops and compares on the falling edge.
module tb_pixel_compositor;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        de = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, X = '0, Y = '0, size = '0;
    logic [7:0]  x_vec = '0, y_vec = '0;
    logic        map_en = 1'b0, wall_on = 1'b0;
    logic [11:0] wall_color = 12'hABC, memdata = 12'h814;
    logic [3:0]  Red, Green, Blue;
    logic        out_valid, dots_ready;

    pixel_compositor dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .de(de),
        .DrawX(DrawX), .DrawY(DrawY), .X(X), .Y(Y), .size(size),
        .x_vec(x_vec), .y_vec(y_vec), .map_en(map_en), .wall_on(wall_on),
        .wall_color(wall_color), .memdata(memdata),
        .Red(Red), .Green(Green), .Blue(Blue),
        .out_valid(out_valid), .dots_ready(dots_ready)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          due;
        int          id;
        logic        valid;
        logic [11:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: compares the output slot each expected pixel is due on.
    always @(negedge Clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL pix#%0d missed: due cycle %0d, now %0d", e.id, e.due, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== e.valid || {Red, Green, Blue} !== e.rgb) begin
                errors++;
                $display("FAIL pix#%0d: valid=%b rgb=%h, expected valid=%b rgb=%h",
                         e.id, out_valid, {Red, Green, Blue}, e.valid, e.rgb);
            end else begin
                $display("pix#%0d ok: valid=%b rgb=%h", e.id, out_valid, {Red, Green, Blue});
            end
        end else if (out_valid === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output at cycle %0d: rgb=%h, expected no valid pixel",
                     cyc, {Red, Green, Blue});
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pix(input logic [9:0] dx, input logic [9:0] dy, input logic m,
                       input logic w, input logic d, input logic [11:0] exp_rgb);
        exp_t e;
        DrawX   = dx;
        DrawY   = dy;
        map_en  = m;
        wall_on = w;
        de      = d;
        e.due   = cyc + 2;
        e.id    = txn;
        e.valid = d;
        e.rgb   = d ? exp_rgb : 12'h000;
        txn++;
        exp_q.push_back(e);
        step();
    endtask

    task automatic idle();
        de = 1'b0;
        step();
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end else begin
            $display("check %s ok: %0d", nm, act);
        end
    endtask

    // Counts clock edges from the frame_start edge (already taken) until
    // dots_ready is seen, driving a checked pixel on every cycle.
    task automatic wait_ready(input logic [9:0] dx, input logic [9:0] dy,
                              input logic [11:0] exp_rgb, output int n);
        n = 1;
        while (dots_ready !== 1'b1 && n < 40) begin
            pix(dx, dy, 1'b1, 1'b0, 1'b1, exp_rgb);
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Power-on reset
        repeat (3) idle();
        Reset = 1'b0;
        chk("por_rgb", int'({Red, Green, Blue}), 0);
        chk("por_valid", int'(out_valid), 0);
        chk("por_ready", int'(dots_ready), 0);

        // Forward view vector, dots at x=100..164 step 8
        X = 10'd100; Y = 10'd100; size = 10'd10; x_vec = 8'd64; y_vec = 8'd0;
        frame_start = 1'b1; idle(); frame_start = 1'b0;
        wait_ready(10'd300, 10'd240, 12'h888, n);
        chk("fwd_ready_latency", n, 11);
        pix(10'd27,  10'd25,  1'b1, 1'b0, 1'b1, 12'hFFF);   // dot1 at 108
        pix(10'd41,  10'd25,  1'b1, 1'b0, 1'b1, 12'hFFF);   // dot8 at 164
        pix(10'd25,  10'd25,  1'b1, 1'b0, 1'b1, 12'hFFF);   // dot beats player
        pix(10'd26,  10'd26,  1'b1, 1'b1, 1'b1, 12'hF70);   // player beats wall
        pix(10'd50,  10'd50,  1'b1, 1'b1, 1'b1, 12'hABC);   // wall
        pix(10'd50,  10'd50,  1'b1, 1'b0, 1'b1, 12'h004);   // background
        pix(10'd160, 10'd120, 1'b1, 1'b0, 1'b1, 12'h004);   // map corner, inclusive
        pix(10'd161, 10'd120, 1'b1, 1'b0, 1'b1, 12'h337);   // just right of map
        pix(10'd100, 10'd121, 1'b1, 1'b0, 1'b1, 12'h337);   // just below map
        pix(10'd27,  10'd25,  1'b0, 1'b0, 1'b1, 12'h337);   // map_en=0

        // Reset held 3 cycles in the middle of a dot calculation
        frame_start = 1'b1; pix(10'd300, 10'd240, 1'b1, 1'b0, 1'b1, 12'h888); frame_start = 1'b0;
        chk("rst_ready_cleared_by_frame", int'(dots_ready), 0);
        pix(10'd300, 10'd240, 1'b1, 1'b0, 1'b1, 12'h888);
        pix(10'd300, 10'd240, 1'b1, 1'b0, 1'b1, 12'h888);
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) void'(exp_q.pop_back());
        Reset = 1'b1;
        DrawX = 10'd300; DrawY = 10'd240; de = 1'b1;
        repeat (3) step();
        Reset = 1'b0;
        chk("rst_rgb", int'({Red, Green, Blue}), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ready", int'(dots_ready), 0);
        pix(10'd27, 10'd25, 1'b1, 1'b0, 1'b1, 12'h004);     // old dots gone
        pix(10'd0,  10'd0,  1'b1, 1'b0, 1'b1, 12'hFFF);     // reset dots at (0,0)
        repeat (15) idle();
        chk("rst_calc_aborted", int'(dots_ready), 0);

        // Backward view vector, dot8 at x=36; live X change ignored
        X = 10'd100; Y = 10'd100; size = 10'd10; x_vec = 8'hC0;
        frame_start = 1'b1; idle(); frame_start = 1'b0;
        wait_ready(10'd300, 10'd240, 12'h888, n);
        chk("bwd_ready_latency", n, 11);
        pix(10'd9,  10'd25, 1'b1, 1'b0, 1'b1, 12'hFFF);     // dot8 at 36
        pix(10'd41, 10'd25, 1'b1, 1'b0, 1'b1, 12'h004);     // previous 164 gone
        X = 10'd50;
        pix(10'd26, 10'd26, 1'b1, 1'b0, 1'b1, 12'hF70);     // disc still at 100
        pix(10'd13, 10'd26, 1'b1, 1'b0, 1'b1, 12'h004);     // no disc at 50
        pix(10'd9,  10'd25, 1'b1, 1'b0, 1'b1, 12'hFFF);     // dots unchanged

        // Restart at k=4 with X=10; old dots visible until commit
        X = 10'd200; x_vec = 8'd16;
        frame_start = 1'b1; pix(10'd9, 10'd25, 1'b1, 1'b0, 1'b1, 12'hFFF); frame_start = 1'b0;
        repeat (4) pix(10'd9, 10'd25, 1'b1, 1'b0, 1'b1, 12'hFFF);
        X = 10'd10;
        frame_start = 1'b1; pix(10'd9, 10'd25, 1'b1, 1'b0, 1'b1, 12'hFFF); frame_start = 1'b0;
        wait_ready(10'd9, 10'd25, 12'hFFF, n);
        chk("restart_ready_latency", n, 11);
        pix(10'd6, 10'd25, 1'b1, 1'b0, 1'b1, 12'hFFF);      // dot7 at 24
        pix(10'd7, 10'd25, 1'b1, 1'b0, 1'b1, 12'h004);      // 28 is 2 from 26
        pix(10'd3, 10'd25, 1'b1, 1'b0, 1'b1, 12'hFFF);      // dot1 at 12
        pix(10'd9, 10'd25, 1'b1, 1'b0, 1'b1, 12'h004);      // old 36 gone
        pix(10'd2, 10'd25, 1'b1, 1'b0, 1'b1, 12'hF70);      // disc at X=10

        // First-person column, h=40
        memdata = 12'h814;
        pix(10'd300, 10'd199, 1'b1, 1'b0, 1'b1, 12'h337);
        pix(10'd300, 10'd200, 1'b1, 1'b0, 1'b1, 12'h888);
        pix(10'd300, 10'd280, 1'b1, 1'b0, 1'b1, 12'h888);
        pix(10'd300, 10'd281, 1'b1, 1'b0, 1'b1, 12'h733);
        // h=510 exceeds Y_CENTER: top is negative, no underflow
        memdata = 12'h8FF;
        pix(10'd300, 10'd0,   1'b1, 1'b0, 1'b1, 12'h888);
        pix(10'd300, 10'd750, 1'b1, 1'b0, 1'b1, 12'h888);
        pix(10'd300, 10'd751, 1'b1, 1'b0, 1'b1, 12'h733);
        // h=0: only the horizon row is wall
        memdata = 12'h000;
        pix(10'd300, 10'd239, 1'b1, 1'b0, 1'b1, 12'h337);
        pix(10'd300, 10'd240, 1'b1, 1'b0, 1'b1, 12'h000);
        pix(10'd300, 10'd241, 1'b1, 1'b0, 1'b1, 12'h733);
        memdata = 12'h814;

        // de pattern 1,0,1 with map_en=0
        pix(10'd27, 10'd240, 1'b0, 1'b0, 1'b1, 12'h888);
        pix(10'd27, 10'd240, 1'b0, 1'b0, 1'b0, 12'h888);
        pix(10'd27, 10'd240, 1'b0, 1'b0, 1'b1, 12'h888);

        repeat (4) idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
